// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared VGA timing constants, total derivation and raw-signal type.
// Revision    : 1.0  initial parametrised release
// ============================================================================
package vga_pkg;

    // 640x480@60 defaults
    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;

    localparam bit POL_ACTIVE_LOW  = 1'b0;
    localparam bit POL_ACTIVE_HIGH = 1'b1;

    // 50 MHz system clock to 25 MHz pixel strobe
    localparam int unsigned STROBE_DIV = 2;

    typedef struct packed {
        logic de;
        logic hs;
        logic vs;
    } vga_raw_t;

    function automatic int unsigned total(input int unsigned active, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : vga_delay_line
// Description : Strobe-enabled shift register of parametrised depth, cleared by reset.
// Revision    : 1.0  initial release
// ============================================================================
module vga_delay_line #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else if (i_en) begin
            r_stage[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_gen
// Description : Parametrised VGA timing: counters, sync/DE with strobe delay, pulses.
// Revision    : 1.0  initial parametrised release
// ============================================================================
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          H_POL    = POL_ACTIVE_LOW,
    parameter bit          V_POL    = POL_ACTIVE_LOW,
    parameter int unsigned LATENCY  = 0,
    parameter int unsigned XW       = 10,
    parameter int unsigned YW       = 10,
    parameter int unsigned FW       = 8
) (
    input  logic          in_clock,
    input  logic          in_reset,
    input  logic          in_strobe,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y,
    output logic          out_hsync,
    output logic          out_vsync,
    output logic          out_de,
    output logic          out_line_start,
    output logic          out_frame_start,
    output logic [FW-1:0] out_frame_cnt
);

    localparam int unsigned c_H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned c_V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0 ||
        LATENCY > 7 || XW == 0 || YW == 0 || FW == 0 ||
        longint'(c_H_TOTAL) > (longint'(1) << XW) ||
        longint'(c_V_TOTAL) > (longint'(1) << YW)) begin : g_bad_params
        $error("vga_timing_gen: illegal timing, latency or width parameters");
    end

    localparam logic [XW-1:0] c_H_LAST   = XW'(c_H_TOTAL - 1);
    localparam logic [XW-1:0] c_H_ACT    = XW'(H_ACTIVE);
    localparam logic [XW-1:0] c_HS_START = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] c_HS_END   = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] c_V_LAST   = YW'(c_V_TOTAL - 1);
    localparam logic [YW-1:0] c_V_ACT    = YW'(V_ACTIVE);
    localparam logic [YW-1:0] c_VS_START = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] c_VS_END   = YW'(V_ACTIVE + V_FP + V_SYNC);

    logic [XW-1:0] r_h_cnt;
    logic [YW-1:0] r_v_cnt;
    logic [FW-1:0] r_frame_cnt;
    logic          r_line_start;
    logic          r_frame_start;
    logic          w_h_last;
    logic          w_v_last;
    logic [XW-1:0] w_h_next;
    logic [YW-1:0] w_v_next;
    vga_raw_t      w_raw_next;
    vga_raw_t      w_raw_dly;

    // Raw signals are decoded from the next counter values so that the
    // first delay stage lines up with out_x/out_y when LATENCY is 0.
    always_comb begin
        w_h_last = (r_h_cnt == c_H_LAST);
        w_v_last = (r_v_cnt == c_V_LAST);
        w_h_next = w_h_last ? '0 : r_h_cnt + 1'b1;
        w_v_next = r_v_cnt;
        if (w_h_last) begin
            w_v_next = w_v_last ? '0 : r_v_cnt + 1'b1;
        end
        w_raw_next.de = (w_h_next < c_H_ACT) && (w_v_next < c_V_ACT);
        w_raw_next.hs = (w_h_next >= c_HS_START) && (w_h_next < c_HS_END);
        w_raw_next.vs = (w_v_next >= c_VS_START) && (w_v_next < c_VS_END);
    end

    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            r_frame_cnt   <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            if (in_strobe) begin
                r_h_cnt       <= w_h_next;
                r_v_cnt       <= w_v_next;
                r_line_start  <= w_h_last;
                r_frame_start <= w_h_last && w_v_last;
                if (w_h_last && w_v_last) begin
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end
            end
        end
    end

    vga_delay_line #(
        .WIDTH(3),
        .DEPTH(int'(LATENCY) + 1)
    ) u_delay (
        .clk (in_clock),
        .rst (in_reset),
        .i_en(in_strobe),
        .i_d (w_raw_next),
        .o_q (w_raw_dly)
    );

    assign out_x           = r_h_cnt;
    assign out_y           = r_v_cnt;
    assign out_frame_cnt   = r_frame_cnt;
    assign out_line_start  = r_line_start;
    assign out_frame_start = r_frame_start;
    assign out_de          = w_raw_dly.de;
    assign out_hsync       = w_raw_dly.hs ^ ~H_POL;
    assign out_vsync       = w_raw_dly.vs ^ ~V_POL;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Directed bench for vga_timing_gen (default, small, small+latency).
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstA = 1'b1, stbA = 1'b0;
    logic rstB = 1'b1, stbB = 1'b0;
    logic rstC = 1'b1, stbC = 1'b0;

    logic [9:0] xA, yA;
    logic [7:0] fcA;
    logic       hsA, vsA, deA, lsA, fsA;
    logic [3:0] xB, xC;
    logic [2:0] yB, yC;
    logic [7:0] fcB;
    logic [1:0] fcC;
    logic       hsB, vsB, deB, lsB, fsB;
    logic       hsC, vsC, deC, lsC, fsC;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    vga_timing_gen u_dut_a (
        .in_clock(clk), .in_reset(rstA), .in_strobe(stbA),
        .out_x(xA), .out_y(yA), .out_hsync(hsA), .out_vsync(vsA), .out_de(deA),
        .out_line_start(lsA), .out_frame_start(fsA), .out_frame_cnt(fcA)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .LATENCY(0), .XW(4), .YW(3), .FW(8)
    ) u_dut_b (
        .in_clock(clk), .in_reset(rstB), .in_strobe(stbB),
        .out_x(xB), .out_y(yB), .out_hsync(hsB), .out_vsync(vsB), .out_de(deB),
        .out_line_start(lsB), .out_frame_start(fsB), .out_frame_cnt(fcB)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .LATENCY(2), .XW(4), .YW(3), .FW(2)
    ) u_dut_c (
        .in_clock(clk), .in_reset(rstC), .in_strobe(stbC),
        .out_x(xC), .out_y(yC), .out_hsync(hsC), .out_vsync(vsC), .out_de(deC),
        .out_line_start(lsC), .out_frame_start(fsC), .out_frame_cnt(fcC)
    );

    task automatic cmp(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model works on p = strobe edges since reset; returns {de, hs_active, vs_active}.
    function automatic bit [2:0] model_raw(input int q, input int ha, input int hf, input int hs,
                                           input int hb, input int va, input int vf, input int vs,
                                           input int vb);
        int ht, vt, x, y;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        x  = q % ht;
        y  = (q / ht) % vt;
        return {(x < ha) && (y < va),
                (x >= ha + hf) && (x < ha + hf + hs),
                (y >= va + vf) && (y < va + vf + vs)};
    endfunction

    task automatic check_inst(input string nm, input int p, input bit ed,
                              input int ha, input int hf, input int hs, input int hb,
                              input int va, input int vf, input int vs, input int vb,
                              input int lat, input int fw,
                              input int ax, input int ay, input int afc,
                              input bit ahs, input bit avs, input bit ade,
                              input bit als, input bit afs);
        int ht, vt, fr;
        bit [2:0] r;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        fr = ht * vt;
        r  = (p >= lat + 1) ? model_raw(p - lat, ha, hf, hs, hb, va, vf, vs, vb) : 3'b000;
        cmp($sformatf("%s.x p=%0d", nm, p), ax, p % ht);
        cmp($sformatf("%s.y p=%0d", nm, p), ay, (p / ht) % vt);
        cmp($sformatf("%s.de p=%0d", nm, p), int'(ade), int'(r[2]));
        cmp($sformatf("%s.hsync p=%0d", nm, p), int'(ahs), int'(!r[1]));
        cmp($sformatf("%s.vsync p=%0d", nm, p), int'(avs), int'(!r[0]));
        cmp($sformatf("%s.line_start p=%0d", nm, p), int'(als), int'(ed && (p % ht == 0)));
        cmp($sformatf("%s.frame_start p=%0d", nm, p), int'(afs), int'(ed && (p % fr == 0)));
        cmp($sformatf("%s.frame_cnt p=%0d", nm, p), afc, (p / fr) % (1 << fw));
    endtask

    int pa = 0, pb = 0, pc = 0;
    bit ea = 1'b0, eb = 1'b0, ec = 1'b0;

    always @(posedge clk) begin
        if (rstA) begin pa <= 0; ea <= 1'b0; end
        else if (stbA) begin pa <= pa + 1; ea <= 1'b1; end
        else ea <= 1'b0;
        if (rstB) begin pb <= 0; eb <= 1'b0; end
        else if (stbB) begin pb <= pb + 1; eb <= 1'b1; end
        else eb <= 1'b0;
        if (rstC) begin pc <= 0; ec <= 1'b0; end
        else if (stbC) begin pc <= pc + 1; ec <= 1'b1; end
        else ec <= 1'b0;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            check_inst("A", pa, ea, 640, 16, 96, 48, 480, 10, 2, 33, 0, 8,
                       int'(xA), int'(yA), int'(fcA), hsA, vsA, deA, lsA, fsA);
            check_inst("B", pb, eb, 8, 2, 3, 1, 4, 1, 2, 1, 0, 8,
                       int'(xB), int'(yB), int'(fcB), hsB, vsB, deB, lsB, fsB);
            check_inst("C", pc, ec, 8, 2, 3, 1, 4, 1, 2, 1, 2, 2,
                       int'(xC), int'(yC), int'(fcC), hsC, vsC, deC, lsC, fsC);
        end
    end

    initial begin
        int last_ls, ls_n, period, to, fsn, first_ls, ls_gap;
        bit [5:0] seen;
        int exp_fc [4] = '{1, 2, 3, 0};

        repeat (3) @(negedge clk);
        rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;
        chk_on = 1'b1;
        cmp("A.reset_x", int'(xA), 0);
        cmp("A.reset_hsync", int'(hsA), 1);
        cmp("A.reset_vsync", int'(vsA), 1);
        cmp("A.reset_de", int'(deA), 0);
        cmp("A.reset_frame_cnt", int'(fcA), 0);

        // Default mode, strobe every second clock
        last_ls = -1; ls_n = 0; period = 0; seen = '0;
        for (int c = 1; c <= 4000; c++) begin
            stbA = ~stbA;
            @(negedge clk);
            if (yA == 10'd0) begin
                if (xA == 10'd655) begin cmp("A.hs@655", int'(hsA), 1); seen[0] = 1'b1; end
                if (xA == 10'd656) begin cmp("A.hs@656", int'(hsA), 0); seen[1] = 1'b1; end
                if (xA == 10'd751) begin cmp("A.hs@751", int'(hsA), 0); seen[2] = 1'b1; end
                if (xA == 10'd752) begin cmp("A.hs@752", int'(hsA), 1); seen[3] = 1'b1; end
                if (xA == 10'd639) begin cmp("A.de@639", int'(deA), 1); seen[4] = 1'b1; end
                if (xA == 10'd640) begin cmp("A.de@640", int'(deA), 0); seen[5] = 1'b1; end
            end
            if (lsA) begin
                if (ls_n == 1) period = c - last_ls;
                last_ls = c;
                ls_n++;
            end
        end
        stbA = 1'b0;
        cmp("A.boundaries_seen", int'(seen), 63);
        cmp("A.line_period", period, 1600);

        // Small mode: stall mid-line at x=5
        stbB = 1'b1;
        to = 0;
        while (xB != 4'd5 && to < 50) begin
            @(negedge clk);
            to++;
        end
        stbB = 1'b0;
        cmp("B.reach_x5", int'(xB), 5);
        repeat (20) begin
            @(negedge clk);
            cmp("B.stall_x", int'(xB), 5);
            cmp("B.stall_y", int'(yB), 0);
            cmp("B.stall_hsync", int'(hsB), 1);
            cmp("B.stall_line_start", int'(lsB), 0);
            cmp("B.stall_frame_start", int'(fsB), 0);
        end
        stbB = 1'b1;
        @(negedge clk);
        cmp("B.resume_x", int'(xB), 6);
        stbB = 1'b0;

        // Small mode: pulse spacing and first frame count
        rstB = 1'b1;
        @(negedge clk);
        rstB = 1'b0;
        stbB = 1'b1;
        first_ls = -1; ls_gap = 0;
        for (int k = 1; k <= 120; k++) begin
            @(negedge clk);
            if (k == 14) cmp("B.line_start@14", int'(lsB), 1);
            if (k == 15) cmp("B.line_start@15", int'(lsB), 0);
            if (k == 111) cmp("B.frame_cnt@111", int'(fcB), 0);
            if (k == 112) begin
                cmp("B.frame_start@112", int'(fsB), 1);
                cmp("B.frame_cnt@112", int'(fcB), 1);
            end
            if (lsB) begin
                if (first_ls >= 0 && ls_gap == 0) ls_gap = k - first_ls;
                if (first_ls < 0) first_ls = k;
            end
        end
        stbB = 1'b0;
        cmp("B.line_interval", ls_gap, 14);

        // Small mode with LATENCY=2 and FW=2
        rstC = 1'b1;
        @(negedge clk);
        rstC = 1'b0;
        stbC = 1'b1;
        fsn = 0;
        for (int k = 1; k <= 470; k++) begin
            @(negedge clk);
            if (k == 113) cmp("C.de@113", int'(deC), 0);
            if (k == 114) cmp("C.de@114", int'(deC), 1);
            if (k == 121) cmp("C.de@121", int'(deC), 1);
            if (k == 122) cmp("C.de@122", int'(deC), 0);
            if (fsC) begin
                if (fsn < 4) cmp($sformatf("C.frame_cnt_seq[%0d]", fsn), int'(fcC), exp_fc[fsn]);
                fsn++;
            end
        end
        cmp("C.frame_start_count", fsn, 4);

        to = 0;
        while (!(xC == 4'd9 && yC == 3'd3) && to < 200) begin
            @(negedge clk);
            to++;
        end
        cmp("C.reach_x9", int'(xC), 9);
        cmp("C.reach_y3", int'(yC), 3);
        rstC = 1'b1;
        @(negedge clk);
        rstC = 1'b0;
        stbC = 1'b0;
        cmp("C.rst_x", int'(xC), 0);
        cmp("C.rst_y", int'(yC), 0);
        cmp("C.rst_de", int'(deC), 0);
        cmp("C.rst_hsync", int'(hsC), 1);
        cmp("C.rst_vsync", int'(vsC), 1);
        cmp("C.rst_frame_cnt", int'(fcC), 0);
        cmp("C.rst_line_start", int'(lsC), 0);

        @(negedge clk);
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 640x480 VGA timing block.
- Generates horizontal and vertical sync, a data-enable signal and pixel coordinates from one clock gated by a pixel strobe.
- Timing, sync polarity and sync/DE delay are set by parameters, so the same block drives any VGA mode.
- Adds line-start and frame-start pulses and a frame counter, for framebuffer readout and animation in the display top level.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
H_POL, 0, hsync active level (0 = active-low)
V_POL, 0, vsync active level
LATENCY, 0, strobe-stage delay of sync/DE relative to x/y (0..7)
XW, 10, width of out_x (must hold H_TOTAL-1)
YW, 10, width of out_y (must hold V_TOTAL-1)
FW, 8, frame counter width

Ports:
in_clock  input  1  system clock (50 MHz)
in_reset  input  1  synchronous, active-high reset
in_strobe  input  1  pixel clock enable; all timing advances only when 1
out_x  output  XW  horizontal counter (0..H_TOTAL-1)
out_y  output  YW  vertical counter (0..V_TOTAL-1)
out_hsync  output  1  horizontal sync, level per H_POL, delayed by LATENCY
out_vsync  output  1  vertical sync, level per V_POL, delayed by LATENCY
out_de  output  1  data enable (active region), delayed by LATENCY
out_line_start  output  1  one-clock pulse when out_x becomes 0
out_frame_start  output  1  one-clock pulse when (out_x,out_y) becomes (0,0)
out_frame_cnt  output  FW  frames completed, wraps modulo 2^FW

Behaviour:
- One clock, in_clock; reset in_reset is synchronous and active-high. All state changes on the rising edge of in_clock.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is the vertical equivalent.
- Region order per line and per frame: active, front porch, sync, back porch.
- Reset values:
  - out_x=0, out_y=0, out_de=0, out_frame_cnt=0.
  - out_hsync=~H_POL, out_vsync=~V_POL.
  - Both pulse outputs are 0.
  - The LATENCY pipeline is filled with inactive values.
- Reset mid-frame takes effect on the next edge, with priority over in_strobe.
- Strobe cycle (in_strobe=1):
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt increments.
  - v_cnt wraps from V_TOTAL-1 to 0 only when h_cnt also wraps.
  - out_frame_cnt increments on that same edge and wraps at 2^FW.
- in_strobe=0: every output holds, except the pulses, which drop to 0.
- out_x and out_y are the registered counters with zero extra latency, intended as framebuffer read address.
- Raw (undelayed) signals:
  - de_raw = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs_raw is active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw uses the vertical equivalent of that range and spans whole lines.
- LATENCY pipeline:
  - de_raw, hs_raw and vs_raw pass through a shift register of depth LATENCY.
  - The register shifts only on strobe cycles.
  - LATENCY=0 means the outputs are the registered raw values with no delay stage.
- Pulse outputs:
  - out_line_start is 1 for exactly one in_clock cycle, on the edge where h_cnt becomes 0.
  - out_frame_start is 1 for one cycle, on the edge where both counters become 0.
  - The pulses are not delayed by LATENCY.
- Simultaneous events: on the last pixel of a frame, the h wrap, v wrap, frame_cnt increment and both pulses all occur on the same edge.
- Arithmetic: all region boundaries are compile-time constants. Counter compares are unsigned at width XW/YW.
- Illegal parameters (XW or YW too narrow, any timing parameter 0, LATENCY>7): an elaboration-time error, not a runtime condition.

Decomposition:
- Shared package vga_pkg holds:
  - default 640x480@60 timing constants;
  - H_TOTAL/V_TOTAL derivation;
  - the polarity localparams.
- The top level also uses vga_pkg for the 25 MHz strobe ratio.
- One natural sub-module, vga_delay_line: a parametrised-depth, strobe-enabled shift register. It is instantiated once with width 3 for {de, hs, vs}.

Test Plan:
- Defaults, LATENCY=0, in_strobe every 2nd clock -> after reset:
  - out_hsync is 0 exactly for x=656..751;
  - out_de=1 for x=0..639, y=0..479;
  - line period is 1600 clocks.
- Small mode (H 8/2/3/1, V 4/1/2/1; H_TOTAL=14, V_TOTAL=8), in_strobe=1 -> out_line_start every 14 clocks, out_frame_start every 112 clocks, out_frame_cnt=1 after the first frame.
- in_strobe held 0 for 20 clocks mid-line at x=5 -> x, y and syncs frozen, pulses 0. Resume with in_strobe=1 -> out_x=6 on the first strobe edge.
- Small mode with LATENCY=2 -> out_de rises exactly 2 strobe edges after out_x returns to 0 on line y=0, and falls 2 strobes after x reaches 8.
- Assert in_reset for one clock at (x=9, y=3), coincident with in_strobe=1 -> next edge: out_x=0, out_y=0, out_de=0, out_hsync=1 (H_POL=0), out_frame_cnt=0, delay line cleared.
- FW=2, run 4 frames -> out_frame_cnt goes 1, 2, 3, 0, incrementing on the out_frame_start edge.
